// File: rtl/complete_buffer.sv
// Completion buffer between the dual-ALU block and the CDB: in-order FIFO with
// empty-queue bypass, one registered broadcast per cycle, and mispredict flush.
module complete_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ROB_W  = 5,
  parameter int unsigned PREG_W = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       fu0_valid,
  input  logic [ROB_W-1:0]           fu0_rob_idx,
  input  logic [PREG_W-1:0]          fu0_prd,
  input  logic                       fu0_wr_en,
  input  logic [31:0]                fu0_result,
  input  logic                       fu0_flag_sign,
  input  logic                       fu0_flag_zero,
  input  logic                       fu1_valid,
  input  logic [ROB_W-1:0]           fu1_rob_idx,
  input  logic [PREG_W-1:0]          fu1_prd,
  input  logic                       fu1_wr_en,
  input  logic [31:0]                fu1_result,
  input  logic                       fu1_flag_sign,
  input  logic                       fu1_flag_zero,
  output logic                       fu_ready,
  output logic                       cdb_valid,
  output logic [ROB_W-1:0]           cdb_rob_idx,
  output logic [PREG_W-1:0]          cdb_prd,
  output logic                       cdb_wr_en,
  output logic [31:0]                cdb_data,
  output logic                       cdb_flag_sign,
  output logic                       cdb_flag_zero,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_idx;
    logic [PREG_W-1:0] prd;
    logic              wr_en;
    logic [31:0]       data;
    logic              flag_sign;
    logic              flag_zero;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count_q;
  logic               cdb_valid_q;
  entry_t             cdb_q;

  entry_t             in0;
  entry_t             in1;
  logic               acc0;
  logic               acc1;
  logic               empty;

  entry_t             cdb_next;
  logic               cdb_valid_next;
  logic               pop_head;
  entry_t             enq_first;
  entry_t             enq_second;
  logic [1:0]         n_enq;
  logic [1:0]         n_in;
  logic [CNT_W-1:0]   count_next;

  assign in0 = '{rob_idx: fu0_rob_idx, prd: fu0_prd, wr_en: fu0_wr_en, data: fu0_result,
                 flag_sign: fu0_flag_sign, flag_zero: fu0_flag_zero};
  assign in1 = '{rob_idx: fu1_rob_idx, prd: fu1_prd, wr_en: fu1_wr_en, data: fu1_result,
                 flag_sign: fu1_flag_sign, flag_zero: fu1_flag_zero};

  // Ready depends only on registered occupancy; net growth is at most one per cycle.
  assign fu_ready = (count_q < CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign acc0     = fu0_valid & fu_ready & ~flush;
  assign acc1     = fu1_valid & fu_ready & ~flush;
  assign n_in     = 2'(acc0) + 2'(acc1);

  // Oldest of {head, fu0, fu1} goes to the CDB; the rest enqueue in age order.
  always_comb begin
    cdb_next       = '0;
    cdb_valid_next = 1'b0;
    pop_head       = 1'b0;
    enq_first      = in0;
    enq_second     = in1;
    n_enq          = 2'd0;
    if (!empty) begin
      cdb_valid_next = 1'b1;
      cdb_next       = mem[head];
      pop_head       = 1'b1;
      if (acc0) begin
        enq_first  = in0;
        enq_second = in1;
        n_enq      = acc1 ? 2'd2 : 2'd1;
      end else if (acc1) begin
        enq_first = in1;
        n_enq     = 2'd1;
      end
    end else if (acc0) begin
      cdb_valid_next = 1'b1;
      cdb_next       = in0;
      if (acc1) begin
        enq_first = in1;
        n_enq     = 2'd1;
      end
    end else if (acc1) begin
      cdb_valid_next = 1'b1;
      cdb_next       = in1;
    end
  end

  assign count_next = count_q + CNT_W'(n_in) - CNT_W'(cdb_valid_next);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else begin
      head        <= head + PTR_W'(pop_head);
      tail        <= tail + PTR_W'(n_enq);
      count_q     <= count_next;
      cdb_valid_q <= cdb_valid_next;
      cdb_q       <= cdb_next;
    end
  end

  // Storage needs no reset; occupancy tracking decides what is live.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (n_enq != 2'd0) mem[tail] <= enq_first;
      if (n_enq == 2'd2) mem[tail + PTR_W'(1)] <= enq_second;
    end
  end

  assign cdb_valid     = cdb_valid_q;
  assign cdb_rob_idx   = cdb_q.rob_idx;
  assign cdb_prd       = cdb_q.prd;
  assign cdb_wr_en     = cdb_q.wr_en;
  assign cdb_data      = cdb_q.data;
  assign cdb_flag_sign = cdb_q.flag_sign;
  assign cdb_flag_zero = cdb_q.flag_zero;
  assign count         = count_q;

endmodule

// File: tb/tb_complete_buffer.sv
// Randomized bench for complete_buffer against an age-ordered queue model.
module tb_complete_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ROB_W  = 5;
  localparam int unsigned PREG_W = 6;

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] prd;
    logic              wr_en;
    logic [31:0]       data;
    logic              sign;
    logic              zero;
  } item_t;

  logic clk = 1'b0;
  logic reset, flush;
  logic fu0_valid, fu0_wr_en, fu0_flag_sign, fu0_flag_zero;
  logic [ROB_W-1:0] fu0_rob_idx;
  logic [PREG_W-1:0] fu0_prd;
  logic [31:0] fu0_result;
  logic fu1_valid, fu1_wr_en, fu1_flag_sign, fu1_flag_zero;
  logic [ROB_W-1:0] fu1_rob_idx;
  logic [PREG_W-1:0] fu1_prd;
  logic [31:0] fu1_result;
  logic fu_ready, cdb_valid, cdb_wr_en, cdb_flag_sign, cdb_flag_zero;
  logic [ROB_W-1:0] cdb_rob_idx;
  logic [PREG_W-1:0] cdb_prd;
  logic [31:0] cdb_data;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_errors = 0;

  item_t mq[$];
  logic  exp_valid;
  item_t exp_item;

  complete_buffer #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu0_valid(fu0_valid), .fu0_rob_idx(fu0_rob_idx), .fu0_prd(fu0_prd),
    .fu0_wr_en(fu0_wr_en), .fu0_result(fu0_result),
    .fu0_flag_sign(fu0_flag_sign), .fu0_flag_zero(fu0_flag_zero),
    .fu1_valid(fu1_valid), .fu1_rob_idx(fu1_rob_idx), .fu1_prd(fu1_prd),
    .fu1_wr_en(fu1_wr_en), .fu1_result(fu1_result),
    .fu1_flag_sign(fu1_flag_sign), .fu1_flag_zero(fu1_flag_zero),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
    .cdb_prd(cdb_prd), .cdb_wr_en(cdb_wr_en), .cdb_data(cdb_data),
    .cdb_flag_sign(cdb_flag_sign), .cdb_flag_zero(cdb_flag_zero), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic item_t rand_item();
    item_t it;
    it.rob   = ROB_W'($urandom);
    it.prd   = PREG_W'($urandom);
    it.wr_en = 1'($urandom);
    it.data  = $urandom;
    it.sign  = 1'($urandom);
    it.zero  = 1'($urandom);
    return it;
  endfunction

  function automatic item_t mk(input int rob, input int prd, input logic wr, input int data,
                               input logic s, input logic z);
    item_t it;
    it.rob = ROB_W'(rob); it.prd = PREG_W'(prd); it.wr_en = wr;
    it.data = 32'(data); it.sign = s; it.zero = z;
    return it;
  endfunction

  task automatic compare_outputs(input string tag);
    item_t got;
    got = '{rob: cdb_rob_idx, prd: cdb_prd, wr_en: cdb_wr_en, data: cdb_data,
            sign: cdb_flag_sign, zero: cdb_flag_zero};
    check({tag, ".valid"}, 64'(cdb_valid), 64'(exp_valid));
    if (exp_valid) check({tag, ".payload"}, 64'(got), 64'(exp_item));
    check({tag, ".count"}, 64'(count), 64'(mq.size()));
    check({tag, ".ready"}, 64'(fu_ready), 64'(mq.size() < DEPTH));
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model, check after the edge.
  task automatic step(input logic v0, input item_t i0, input logic v1, input item_t i1,
                      input logic fl, input string tag);
    item_t all[$];
    logic  rdy;
    rdy = (mq.size() < DEPTH);
    fu0_valid = v0; fu0_rob_idx = i0.rob; fu0_prd = i0.prd; fu0_wr_en = i0.wr_en;
    fu0_result = i0.data; fu0_flag_sign = i0.sign; fu0_flag_zero = i0.zero;
    fu1_valid = v1; fu1_rob_idx = i1.rob; fu1_prd = i1.prd; fu1_wr_en = i1.wr_en;
    fu1_result = i1.data; fu1_flag_sign = i1.sign; fu1_flag_zero = i1.zero;
    flush = fl;
    if (fl) begin
      mq.delete();
      exp_valid = 1'b0;
    end else begin
      all = mq;
      if (v0 && rdy) all.push_back(i0);
      if (v1 && rdy) all.push_back(i1);
      exp_valid = (all.size() > 0);
      if (exp_valid) exp_item = all.pop_front();
      mq = all;
    end
    @(negedge clk);
    compare_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, '0, 1'b0, '0, 1'b0, tag);
  endtask

  // Async reset pulse between edges; outputs must clear without waiting for a clock.
  task automatic pulse_reset(input string tag);
    fu0_valid = 1'b0; fu1_valid = 1'b0; flush = 1'b0;
    reset = 1'b1;
    #1;
    check({tag, ".valid"}, 64'(cdb_valid), 64'd0);
    check({tag, ".data"}, 64'(cdb_data), 64'd0);
    check({tag, ".count"}, 64'(count), 64'd0);
    check({tag, ".ready"}, 64'(fu_ready), 64'd1);
    mq.delete();
    exp_valid = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    compare_outputs({tag, ".after"});
  endtask

  initial begin
    item_t a, b;
    logic v0, v1, fl;
    reset = 1'b1; flush = 1'b0;
    fu0_valid = 1'b0; fu1_valid = 1'b0;
    {fu0_rob_idx, fu0_prd, fu0_wr_en, fu0_result, fu0_flag_sign, fu0_flag_zero} = '0;
    {fu1_rob_idx, fu1_prd, fu1_wr_en, fu1_result, fu1_flag_sign, fu1_flag_zero} = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset.valid", 64'(cdb_valid), 64'd0);
    check("reset.rob", 64'(cdb_rob_idx), 64'd0);
    check("reset.data", 64'(cdb_data), 64'd0);
    check("reset.count", 64'(count), 64'd0);
    check("reset.ready", 64'(fu_ready), 64'd1);
    reset = 1'b0;
    exp_valid = 1'b0;
    @(negedge clk);

    // Single fu0 result bypasses the empty queue.
    step(1'b1, mk(3, 9, 1'b1, 32'h5, 1'b0, 1'b0), 1'b0, '0, 1'b0, "bypass");
    check("bypass.data", 64'(cdb_data), 64'h5);
    idle("bypass.idle");

    // Dual issue: fu0 first, fu1 one cycle later.
    step(1'b1, mk(1, 2, 1'b1, 32'hA, 1'b0, 1'b0), 1'b1, mk(2, 3, 1'b1, 32'hB, 1'b0, 1'b0),
         1'b0, "dual");
    check("dual.data0", 64'(cdb_data), 64'hA);
    idle("dual.drain");
    check("dual.data1", 64'(cdb_data), 64'hB);
    idle("dual.empty");

    // Four back-to-back dual issues fill the buffer, then drain in order.
    for (int i = 0; i < 4; i++)
      step(1'b1, mk(2*i, 2*i+1, 1'b1, 100+2*i, 1'b0, 1'b0),
           1'b1, mk(2*i+1, 2*i+2, 1'b1, 101+2*i, 1'b1, 1'b0), 1'b0, "fill");
    check("fill.full_ready", 64'(fu_ready), 64'd0);
    for (int i = 0; i < 5; i++) idle("fill.drain");

    // Flush at count 3 discards queued entries and the flush-cycle inputs.
    step(1'b1, mk(20, 20, 1'b1, 200, 1'b0, 1'b0), 1'b1, mk(21, 21, 1'b1, 201, 1'b0, 1'b0),
         1'b0, "pre_flush");
    step(1'b1, mk(22, 22, 1'b1, 202, 1'b0, 1'b0), 1'b1, mk(23, 23, 1'b1, 203, 1'b0, 1'b0),
         1'b0, "pre_flush");
    step(1'b1, mk(24, 24, 1'b1, 204, 1'b0, 1'b0), 1'b1, mk(25, 25, 1'b1, 205, 1'b0, 1'b0),
         1'b0, "pre_flush");
    check("pre_flush.count", 64'(count), 64'd3);
    step(1'b1, mk(26, 26, 1'b1, 206, 1'b0, 1'b0), 1'b1, mk(27, 27, 1'b1, 207, 1'b0, 1'b0),
         1'b1, "flush");
    for (int i = 0; i < 3; i++) idle("post_flush");

    // Reset while draining with two entries queued.
    step(1'b1, mk(8, 8, 1'b1, 80, 1'b0, 1'b0), 1'b1, mk(9, 9, 1'b1, 81, 1'b0, 1'b0),
         1'b0, "pre_reset");
    step(1'b1, mk(10, 10, 1'b1, 82, 1'b0, 1'b0), 1'b1, mk(11, 11, 1'b1, 83, 1'b0, 1'b0),
         1'b0, "pre_reset");
    check("pre_reset.count", 64'(count), 64'd2);
    pulse_reset("mid_reset");
    idle("post_reset");

    // fu1-only branch result: broadcast with wr_en low.
    step(1'b0, '0, 1'b1, mk(7, 4, 1'b0, 32'h0, 1'b0, 1'b1), 1'b0, "fu1_only");
    check("fu1_only.wr_en", 64'(cdb_wr_en), 64'd0);
    check("fu1_only.zero", 64'(cdb_flag_zero), 64'd1);
    idle("fu1_only.idle");

    // Random traffic with occasional flush and reset; valids only offered while ready.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset("rand_reset");
      end else begin
        a  = rand_item();
        b  = rand_item();
        v0 = ($urandom_range(0, 99) < 60) && (mq.size() < DEPTH);
        v1 = ($urandom_range(0, 99) < 50) && (mq.size() < DEPTH);
        fl = ($urandom_range(0, 49) == 0);
        step(v0, a, v1, b, fl, "rand");
      end
    end
    for (int i = 0; i < DEPTH + 1; i++) idle("final_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
